// File: rtl/tcdm_mem_init_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tcdm_mem_init_pkg
// Description : Shared types and constants for the TCDM memory init master.
// Revision    : 1.0 - initial release
// ============================================================================
package tcdm_mem_init_pkg;

   localparam int unsigned c_default_max_outstanding = 2;
   localparam logic [3:0]  c_be_full                 = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   typedef enum logic {
      MODE_FILL  = 1'b0,
      MODE_CHECK = 1'b1
   } mode_e;

   // Word-aligned byte address of word idx, wrapping modulo 2^32.
   function automatic logic [31:0] word_addr(input logic [31:0] base,
                                             input logic [31:0] idx);
      return {base[31:2], 2'b00} + {idx[29:0], 2'b00};
   endfunction

endpackage
`default_nettype wire

// File: rtl/tcdm_init_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : tcdm_init_pattern_gen
// Description : Sequential data pattern source: seed, or seed plus word offset.
// Revision    : 1.0 - initial release
// ============================================================================
module tcdm_init_pattern_gen (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] i_seed,
   input  logic        i_incr,
   input  logic        i_advance,
   input  logic        i_clear,
   output logic [31:0] o_value
);

   logic [31:0] r_offset;

   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_offset <= 32'd0;
      end else if (i_advance) begin
         r_offset <= r_offset + 32'd1;
      end
   end

   assign o_value = i_incr ? (i_seed + r_offset) : i_seed;

endmodule
`default_nettype wire

// File: rtl/tcdm_mem_init_master.sv
`default_nettype none
// ============================================================================
// Module      : tcdm_mem_init_master
// Description : TCDM master that fills a word region with a pattern or reads
//               it back and checks it, with bounded outstanding requests.
// Revision    : 1.0 - initial release
// ============================================================================
module tcdm_mem_init_master
   import tcdm_mem_init_pkg::*;
#(
   parameter int unsigned MAX_OUTSTANDING = c_default_max_outstanding,
   parameter int unsigned LEN_WIDTH       = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 cmd_valid_i,
   output logic                 cmd_ready_o,
   input  logic [31:0]          cmd_base_i,
   input  logic [LEN_WIDTH-1:0] cmd_len_i,
   input  logic                 cmd_mode_i,
   input  logic [31:0]          cmd_pattern_i,
   input  logic                 cmd_incr_i,
   input  logic                 abort_i,
   output logic                 tcdm_req_o,
   output logic [31:0]          tcdm_add_o,
   output logic                 tcdm_wen_o,
   output logic [31:0]          tcdm_wdata_o,
   output logic [3:0]           tcdm_be_o,
   input  logic                 tcdm_gnt_i,
   input  logic                 tcdm_r_valid_i,
   input  logic [31:0]          tcdm_r_rdata_i,
   input  logic                 tcdm_r_opc_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 err_o,
   output logic [LEN_WIDTH-1:0] err_cnt_o,
   output logic [31:0]          first_err_addr_o
);

   localparam int unsigned          c_out_w   = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [c_out_w-1:0]   c_max_out = c_out_w'(MAX_OUTSTANDING);
   localparam logic [c_out_w-1:0]   c_out_one = c_out_w'(1);
   localparam logic [LEN_WIDTH-1:0] c_len_one = LEN_WIDTH'(1);

   state_e                 r_state;
   state_e                 w_state_next;
   logic [31:0]            r_base;
   logic [LEN_WIDTH-1:0]   r_len;
   mode_e                  r_mode;
   logic [31:0]            r_pattern;
   logic                   r_incr;
   logic [LEN_WIDTH-1:0]   r_issue_idx;
   logic [LEN_WIDTH-1:0]   r_rsp_idx;
   logic [c_out_w-1:0]     r_outstanding;
   logic [c_out_w-1:0]     w_out_next;
   logic                   r_err;
   logic [LEN_WIDTH-1:0]   r_err_cnt;
   logic [31:0]            r_first_err_addr;

   logic                   w_issuing;
   logic                   w_slot;
   logic                   w_accept;
   logic                   w_xfer;
   logic                   w_rsp;
   logic                   w_last;
   logic                   w_err;
   logic [31:0]            w_issue_val;
   logic [31:0]            w_rsp_val;

   tcdm_init_pattern_gen u_issue_gen (
      .clk       (clk_i),
      .rst       (rst_i),
      .i_seed    (r_pattern),
      .i_incr    (r_incr),
      .i_advance (w_xfer),
      .i_clear   (w_accept),
      .o_value   (w_issue_val)
   );

   tcdm_init_pattern_gen u_rsp_gen (
      .clk       (clk_i),
      .rst       (rst_i),
      .i_seed    (r_pattern),
      .i_incr    (r_incr),
      .i_advance (w_rsp),
      .i_clear   (w_accept),
      .o_value   (w_rsp_val)
   );

   // A response arriving this cycle frees a slot for a same-cycle request.
   assign w_issuing = (r_state == ST_ISSUE);
   assign w_slot    = (r_outstanding < c_max_out) || tcdm_r_valid_i;
   assign w_accept  = cmd_valid_i && cmd_ready_o;
   assign w_xfer    = tcdm_req_o && tcdm_gnt_i;
   assign w_rsp     = tcdm_r_valid_i && (r_outstanding != '0);
   assign w_last    = w_xfer && (r_issue_idx == (r_len - c_len_one));
   assign w_err     = w_rsp && (tcdm_r_opc_i ||
                       ((r_mode == MODE_CHECK) && (tcdm_r_rdata_i != w_rsp_val)));

   assign tcdm_req_o   = w_issuing && !abort_i && w_slot;
   assign tcdm_add_o   = w_issuing ? word_addr(r_base, 32'(r_issue_idx)) : 32'd0;
   assign tcdm_wen_o   = w_issuing ? (r_mode == MODE_CHECK) : 1'b1;
   assign tcdm_wdata_o = w_issuing ? w_issue_val : 32'd0;
   assign tcdm_be_o    = w_issuing ? c_be_full : 4'h0;

   assign err_o            = r_err;
   assign err_cnt_o        = r_err_cnt;
   assign first_err_addr_o = r_first_err_addr;

   always_comb begin
      w_out_next = r_outstanding;
      if (w_xfer && !w_rsp) begin
         w_out_next = r_outstanding + c_out_one;
      end else if (!w_xfer && w_rsp) begin
         w_out_next = r_outstanding - c_out_one;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      cmd_ready_o  = 1'b0;
      busy_o       = 1'b1;
      done_o       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            busy_o      = 1'b0;
            cmd_ready_o = !rst_i;
            if (cmd_valid_i && !rst_i) begin
               w_state_next = (cmd_len_i == '0) ? ST_DONE : ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (abort_i || w_last) begin
               w_state_next = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (w_out_next == '0) begin
               w_state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            done_o       = 1'b1;
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_base           <= 32'd0;
         r_len            <= '0;
         r_mode           <= MODE_FILL;
         r_pattern        <= 32'd0;
         r_incr           <= 1'b0;
         r_issue_idx      <= '0;
         r_rsp_idx        <= '0;
         r_outstanding    <= '0;
         r_err            <= 1'b0;
         r_err_cnt        <= '0;
         r_first_err_addr <= 32'd0;
      end else begin
         r_outstanding <= w_out_next;
         if (w_accept) begin
            r_base           <= {cmd_base_i[31:2], 2'b00};
            r_len            <= cmd_len_i;
            r_mode           <= mode_e'(cmd_mode_i);
            r_pattern        <= cmd_pattern_i;
            r_incr           <= cmd_incr_i;
            r_issue_idx      <= '0;
            r_rsp_idx        <= '0;
            r_err            <= 1'b0;
            r_err_cnt        <= '0;
            r_first_err_addr <= 32'd0;
         end else begin
            if (w_xfer) begin
               r_issue_idx <= r_issue_idx + c_len_one;
            end
            if (w_rsp) begin
               r_rsp_idx <= r_rsp_idx + c_len_one;
            end
            if (w_err) begin
               r_err <= 1'b1;
               if (r_err_cnt != {LEN_WIDTH{1'b1}}) begin
                  r_err_cnt <= r_err_cnt + c_len_one;
               end
               // Only the first failing word of a command is recorded.
               if (!r_err) begin
                  r_first_err_addr <= word_addr(r_base, 32'(r_rsp_idx));
               end
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_tcdm_mem_init_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_tcdm_mem_init_master
// Description : Directed self-checking bench with a TCDM slave model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tcdm_mem_init_master;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [31:0] cmd_base;
   logic [15:0] cmd_len;
   logic        cmd_mode;
   logic [31:0] cmd_pattern;
   logic        cmd_incr;
   logic        abort;
   logic        req;
   logic [31:0] add;
   logic        wen;
   logic [31:0] wdata;
   logic [3:0]  be;
   logic        gnt;
   logic        r_valid = 1'b0;
   logic [31:0] r_rdata = 32'd0;
   logic        r_opc   = 1'b0;
   logic        busy;
   logic        done;
   logic        err;
   logic [15:0] err_cnt;
   logic [31:0] first_err;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   tcdm_mem_init_master #(.MAX_OUTSTANDING(2), .LEN_WIDTH(16)) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .cmd_valid_i      (cmd_valid),
      .cmd_ready_o      (cmd_ready),
      .cmd_base_i       (cmd_base),
      .cmd_len_i        (cmd_len),
      .cmd_mode_i       (cmd_mode),
      .cmd_pattern_i    (cmd_pattern),
      .cmd_incr_i       (cmd_incr),
      .abort_i          (abort),
      .tcdm_req_o       (req),
      .tcdm_add_o       (add),
      .tcdm_wen_o       (wen),
      .tcdm_wdata_o     (wdata),
      .tcdm_be_o        (be),
      .tcdm_gnt_i       (gnt),
      .tcdm_r_valid_i   (r_valid),
      .tcdm_r_rdata_i   (r_rdata),
      .tcdm_r_opc_i     (r_opc),
      .busy_o           (busy),
      .done_o           (done),
      .err_o            (err),
      .err_cnt_o        (err_cnt),
      .first_err_addr_o (first_err)
   );

   // ---------------- slave model ----------------
   int          lat          = 1;
   int          stall_word   = -1;
   int          stall_len    = 0;
   int          opc_word     = -1;
   logic        corrupt_en   = 1'b0;
   logic [31:0] corrupt_addr = 32'd0;

   int grant_total = 0;
   int s_stalled   = 0;
   int rsp_total   = 0;
   int stall_total = 0;
   int s_out       = 0;
   int max_out     = 0;
   int unstable    = 0;
   int s_cyc       = 0;
   logic        prev_stall = 1'b0;
   logic [31:0] prev_add   = 32'd0;
   logic [31:0] prev_wdata = 32'd0;

   logic [31:0] mem [logic [31:0]];
   logic [31:0] log_add   [$];
   logic [31:0] log_wdata [$];
   logic        log_wen   [$];
   logic [3:0]  log_be    [$];

   typedef struct packed {
      int          due;
      logic [31:0] data;
      logic        opc;
   } rsp_t;
   rsp_t rq [$];

   logic w_stall;
   assign w_stall = (grant_total == stall_word) && (s_stalled < stall_len);
   assign gnt     = req && !w_stall;

   function automatic logic [31:0] rd(input logic [31:0] a);
      logic [31:0] v;
      v = mem.exists(a) ? mem[a] : 32'd0;
      if (corrupt_en && (a == corrupt_addr)) v = v ^ 32'hFFFF_0000;
      return v;
   endfunction

   always @(posedge clk) begin
      rsp_t e;
      if (r_valid) rsp_total++;
      if (r_valid && s_out > 0) s_out--;
      if (prev_stall && ((add != prev_add) || (wdata != prev_wdata))) unstable++;
      prev_stall = req && !gnt;
      prev_add   = add;
      prev_wdata = wdata;
      if (req && w_stall) stall_total++;
      if (req && gnt) begin
         e.due  = s_cyc + lat - 1;
         e.data = wen ? rd(add) : 32'd0;
         e.opc  = (grant_total == opc_word);
         if (!wen) mem[add] = wdata;
         log_add.push_back(add);
         log_wdata.push_back(wdata);
         log_wen.push_back(wen);
         log_be.push_back(be);
         rq.push_back(e);
         s_out++;
         if (s_out > max_out) max_out = s_out;
         grant_total <= grant_total + 1;
         s_stalled   <= 0;
      end else if (req && w_stall) begin
         s_stalled <= s_stalled + 1;
      end
      if (rq.size() > 0 && rq[0].due == s_cyc) begin
         e = rq.pop_front();
         r_valid <= 1'b1;
         r_rdata <= e.data;
         r_opc   <= e.opc;
      end else begin
         r_valid <= 1'b0;
         r_rdata <= 32'd0;
         r_opc   <= 1'b0;
      end
      s_cyc++;
   end

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic start_cmd(input logic [31:0] b, input logic [15:0] l, input logic m,
                            input logic [31:0] p, input logic inc);
      cmd_base    = b;
      cmd_len     = l;
      cmd_mode    = m;
      cmd_pattern = p;
      cmd_incr    = inc;
      cmd_valid   = 1'b1;
      check("cmd_ready_before_accept", 32'(cmd_ready), 32'd1);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int start, output int cyc);
      cyc = start;
      while (!done && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      check("done_within_budget", 32'(cyc < 200), 32'd1);
   endtask

   int g0, r0, st0, un0, cyc, n;

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_base = 32'd0; cmd_len = 16'd0; cmd_mode = 1'b0;
      cmd_pattern = 32'd0; cmd_incr = 1'b0; abort = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      check("rst_req", 32'(req), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("rst_ready_after", 32'(cmd_ready), 32'd1);
      check("rst_wen", 32'(wen), 32'd1);
      check("rst_add", add, 32'd0);
      check("rst_wdata", wdata, 32'd0);
      check("rst_be", 32'(be), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_err_cnt", 32'(err_cnt), 32'd0);
      check("rst_first_err", first_err, 32'd0);

      // Fill, 1-cycle slave
      g0 = grant_total; r0 = rsp_total;
      start_cmd(32'h1C01_0000, 16'd4, 1'b0, 32'hA5A5_0000, 1'b1);
      check("fill_busy", 32'(busy), 32'd1);
      wait_done(1, cyc);
      check("fill_latency", 32'(cyc), 32'd6);
      check("fill_grants", 32'(grant_total - g0), 32'd4);
      check("fill_responses", 32'(rsp_total - r0), 32'd4);
      check("fill_err", 32'(err), 32'd0);
      for (int i = 0; i < 4; i++) begin
         check("fill_addr", log_add[g0 + i], 32'h1C01_0000 + 32'(4 * i));
         check("fill_data", log_wdata[g0 + i], 32'hA5A5_0000 + 32'(i));
         check("fill_wen", 32'(log_wen[g0 + i]), 32'd0);
         check("fill_be", 32'(log_be[g0 + i]), 32'hF);
      end
      @(negedge clk);
      check("fill_done_one_pulse", 32'(done), 32'd0);
      check("fill_idle_busy", 32'(busy), 32'd0);

      // Check with one corrupted word
      corrupt_en = 1'b1; corrupt_addr = 32'h1C01_0008;
      g0 = grant_total;
      start_cmd(32'h1C01_0000, 16'd4, 1'b1, 32'hA5A5_0000, 1'b1);
      wait_done(1, cyc);
      check("chk_latency", 32'(cyc), 32'd6);
      check("chk_wen", 32'(log_wen[g0]), 32'd1);
      check("chk_err", 32'(err), 32'd1);
      check("chk_err_cnt", 32'(err_cnt), 32'd1);
      check("chk_first_err", first_err, 32'h1C01_0008);
      corrupt_en = 1'b0;
      @(negedge clk);

      // Stall on word 1 with a 3-cycle slave
      lat = 3; stall_word = grant_total + 1; stall_len = 3;
      g0 = grant_total; st0 = stall_total; un0 = unstable;
      start_cmd(32'h1C01_0000, 16'd4, 1'b0, 32'hA5A5_0000, 1'b1);
      wait_done(1, cyc);
      check("stall_latency", 32'(cyc), 32'd12);
      check("stall_cycles", 32'(stall_total - st0), 32'd3);
      check("stall_stable", 32'(unstable - un0), 32'd0);
      check("stall_grants", 32'(grant_total - g0), 32'd4);
      check("stall_word1_addr", log_add[g0 + 1], 32'h1C01_0004);
      check("stall_word1_data", log_wdata[g0 + 1], 32'hA5A5_0001);
      check("stall_max_out", 32'(max_out), 32'd2);
      stall_word = -1;
      @(negedge clk);

      // Clean check through the outstanding limit
      start_cmd(32'h1C01_0000, 16'd4, 1'b1, 32'hA5A5_0000, 1'b1);
      wait_done(1, cyc);
      check("lat3_latency", 32'(cyc), 32'd9);
      check("lat3_err_cnt", 32'(err_cnt), 32'd0);
      check("lat3_max_out", 32'(max_out), 32'd2);
      lat = 1;
      @(negedge clk);

      // Address wrap, no increment
      g0 = grant_total;
      start_cmd(32'hFFFF_FFF8, 16'd3, 1'b0, 32'h1111_0000, 1'b0);
      wait_done(1, cyc);
      check("wrap_latency", 32'(cyc), 32'd5);
      check("wrap_addr0", log_add[g0], 32'hFFFF_FFF8);
      check("wrap_addr1", log_add[g0 + 1], 32'hFFFF_FFFC);
      check("wrap_addr2", log_add[g0 + 2], 32'h0000_0000);
      check("wrap_data2", log_wdata[g0 + 2], 32'h1111_0000);
      @(negedge clk);

      // Zero length
      g0 = grant_total;
      start_cmd(32'h1C01_0000, 16'd0, 1'b0, 32'h0, 1'b0);
      wait_done(1, cyc);
      check("zero_latency", 32'(cyc), 32'd1);
      check("zero_grants", 32'(grant_total - g0), 32'd0);
      @(negedge clk);

      // Abort after two grants, 3-cycle slave
      lat = 3; g0 = grant_total; r0 = rsp_total;
      start_cmd(32'h1C05_0000, 16'd8, 1'b0, 32'h5555_0000, 1'b1);
      n = 1;
      while (grant_total < g0 + 2 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("abort_wait_n", 32'(n), 32'd3);
      abort = 1'b1;
      wait_done(n, cyc);
      abort = 1'b0;
      check("abort_latency", 32'(cyc), 32'd6);
      check("abort_grants", 32'(grant_total - g0), 32'd2);
      check("abort_responses", 32'(rsp_total - r0), 32'd2);
      lat = 1;
      @(negedge clk);

      // Error opcode on a fill response
      opc_word = grant_total + 1;
      start_cmd(32'h1C02_0000, 16'd2, 1'b0, 32'h0, 1'b1);
      wait_done(1, cyc);
      check("opc_err_cnt", 32'(err_cnt), 32'd1);
      check("opc_err", 32'(err), 32'd1);
      check("opc_first_err", first_err, 32'h1C02_0004);
      opc_word = -1;
      @(negedge clk);
      check("opc_err_sticky", 32'(err), 32'd1);
      start_cmd(32'h1C03_0000, 16'd1, 1'b0, 32'h0, 1'b0);
      check("err_cleared", 32'(err), 32'd0);
      wait_done(1, cyc);
      check("clean_err_cnt", 32'(err_cnt), 32'd0);
      @(negedge clk);

      // Reset mid-ISSUE with a late erroring response
      lat = 3; opc_word = grant_total; g0 = grant_total; r0 = rsp_total;
      start_cmd(32'h1C04_0000, 16'd8, 1'b0, 32'h0, 1'b1);
      n = 0;
      while (grant_total < g0 + 1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      rst = 1'b1;
      @(negedge clk);
      check("midrst_req", 32'(req), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_ready", 32'(cmd_ready), 32'd0);
      check("midrst_add", add, 32'd0);
      check("midrst_wen", 32'(wen), 32'd1);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      opc_word = -1;
      check("late_rsp_seen", 32'(rsp_total - r0), 32'd2);
      check("late_err", 32'(err), 32'd0);
      check("late_err_cnt", 32'(err_cnt), 32'd0);
      check("late_ready", 32'(cmd_ready), 32'd1);
      lat = 1;
      start_cmd(32'h1C06_0000, 16'd2, 1'b0, 32'h0, 1'b1);
      wait_done(1, cyc);
      check("post_rst_latency", 32'(cyc), 32'd4);
      check("post_rst_err", 32'(err), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
